// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C byte engine
package i2c_pkg;
    localparam int DATA_WIDTH = 8;
    typedef enum logic {RW_WRITE = 1'b0, RW_READ = 1'b1} r_w_t;
    typedef enum logic [2:0] {CMD_NOP, CMD_START, CMD_STOP, CMD_WRITE, CMD_READ} bit_cmd_t;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_WRITE, ST_READ, ST_ACK, ST_STOP, ST_DONE} byte_state_t;
endpackage

// File: rtl/i2_ctrl_if.sv
// i2_ctrl_if: command-side bundle between a loader and the I2C byte engine
interface i2_ctrl_if;
    import i2c_pkg::*;
    logic start, stop, read, write, ack_in, cmd_ack;
    logic [DATA_WIDTH-1:0] din, dout;
    modport host (output start, stop, read, write, ack_in, din, input cmd_ack, dout);
    modport engine (input start, stop, read, write, ack_in, din, output cmd_ack, dout);
endinterface

// File: rtl/i2c_bit_ctrl.sv
// i2c_bit_ctrl: runs one bus symbol as 4 prescaled quarters with clock stretching
module i2c_bit_ctrl
    import i2c_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             ena,
    input  logic [CNT_W-1:0] clk_cnt,
    input  bit_cmd_t         cmd,
    input  logic             din_bit,
    output logic             done,
    output logic             rx_bit,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             scl_oen,
    output logic             sda_oen
);
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       q_q;
    logic             scl_hold_q, sda_hold_q, tick, last;

    // pad levels for the current quarter; idle keeps the last driven levels
    always_comb begin
        scl_oen = scl_hold_q;
        sda_oen = sda_hold_q;
        case (cmd)
            CMD_START: begin scl_oen = q_q != 2'd3; sda_oen = !q_q[1]; end
            CMD_STOP:  begin scl_oen = q_q != 2'd0; sda_oen = q_q == 2'd3; end
            CMD_WRITE: begin scl_oen = q_q[0] ^ q_q[1]; sda_oen = din_bit; end
            CMD_READ:  begin scl_oen = q_q[0] ^ q_q[1]; sda_oen = 1'b1; end
            default:   ;
        endcase
        tick = ena && cmd != CMD_NOP && !(scl_oen && !scl_i);
        last = cnt_q == clk_cnt;
        done = tick && last && q_q == 2'd3;
    end

    // prescaler, quarter counter, pad hold and read sampling at end of quarter 2
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q      <= '0;
            q_q        <= '0;
            scl_hold_q <= 1'b1;
            sda_hold_q <= 1'b1;
            rx_bit     <= 1'b0;
        end else if (ena) begin
            scl_hold_q <= scl_oen;
            sda_hold_q <= sda_oen;
            if (tick) begin
                cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
                if (last) q_q <= q_q + 2'd1;
                if (last && q_q == 2'd2) rx_bit <= sda_i;
            end
        end
    end
endmodule

// File: rtl/i2c_byte_ctrl.sv
// i2c_byte_ctrl: byte-level I2C master sequencing START, byte, ACK and STOP
module i2c_byte_ctrl
    import i2c_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  ena,
    input  logic [CNT_W-1:0]      clk_cnt,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  read,
    input  logic                  write,
    input  logic                  ack_in,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  cmd_ack,
    output logic                  ack_out,
    output logic                  i2c_busy,
    output logic                  i2c_al,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  scl_i,
    output logic                  scl_o,
    output logic                  scl_oen,
    input  logic                  sda_i,
    output logic                  sda_o,
    output logic                  sda_oen
);
    byte_state_t           state_q, state_d;
    bit_cmd_t              bit_cmd;
    r_w_t                  rw_q;
    logic [DATA_WIDTH-1:0] sr_q;
    logic [2:0]            bit_q;
    logic                  start_q, stop_q, byte_q, ack_in_q, ack_bit_q, dly_q;
    logic                  accept, done, rx_bit, din_bit;

    assign i2c_al = 1'b0;
    assign scl_o  = 1'b0;
    assign sda_o  = 1'b0;

    // command accept and symbol sequencing
    always_comb begin
        accept  = ena && state_q == ST_IDLE && (start || stop || read || write);
        state_d = state_q;
        case (state_q)
            ST_IDLE:           if (accept) state_d = start ? ST_START : read ? ST_READ : write ? ST_WRITE : ST_STOP;
            ST_START:          if (done) state_d = byte_q ? (rw_q == RW_READ ? ST_READ : ST_WRITE) : stop_q ? ST_STOP : ST_DONE;
            ST_WRITE, ST_READ: if (done && bit_q == 3'd7) state_d = ST_ACK;
            ST_ACK:            if (done) state_d = stop_q ? ST_STOP : ST_DONE;
            ST_STOP:           if (done) state_d = ST_DONE;
            ST_DONE:           if (dly_q) state_d = ST_IDLE;
            default:           state_d = ST_IDLE;
        endcase
    end

    // bit command and data bit for the symbol engine; the 9th bit flips direction
    always_comb begin
        bit_cmd = CMD_NOP;
        case (state_q)
            ST_START: bit_cmd = CMD_START;
            ST_STOP:  bit_cmd = CMD_STOP;
            ST_WRITE: bit_cmd = CMD_WRITE;
            ST_READ:  bit_cmd = CMD_READ;
            ST_ACK:   bit_cmd = rw_q == RW_READ ? CMD_WRITE : CMD_READ;
            default:  ;
        endcase
        din_bit = state_q == ST_ACK ? ack_in_q : sr_q[DATA_WIDTH-1];
    end

    // state register, frozen while disabled
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) state_q <= ST_IDLE;
        else if (ena) state_q <= state_d;
    end

    // command latch, shift register, bus ownership and result registers
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            byte_q    <= 1'b0;
            rw_q      <= RW_WRITE;
            ack_in_q  <= 1'b0;
            sr_q      <= '0;
            bit_q     <= '0;
            ack_bit_q <= 1'b0;
            dly_q     <= 1'b0;
            cmd_ack   <= 1'b0;
            ack_out   <= 1'b0;
            dout      <= '0;
            i2c_busy  <= 1'b0;
        end else if (ena) begin
            cmd_ack <= state_q == ST_DONE && dly_q;
            dly_q   <= state_q == ST_DONE && !dly_q;
            if (accept) begin
                start_q  <= start;
                stop_q   <= stop;
                byte_q   <= read || write;
                rw_q     <= read ? RW_READ : RW_WRITE;
                ack_in_q <= ack_in;
                sr_q     <= din;
                bit_q    <= '0;
            end
            if (done && (state_q == ST_WRITE || state_q == ST_READ)) begin
                sr_q  <= {sr_q[DATA_WIDTH-2:0], rx_bit};
                bit_q <= bit_q + 3'd1;
            end
            if (done && state_q == ST_ACK) ack_bit_q <= rx_bit;
            if (done && state_q == ST_START) i2c_busy <= 1'b1;
            if (done && state_q == ST_STOP) i2c_busy <= 1'b0;
            if (state_q == ST_DONE && dly_q && byte_q) begin
                if (rw_q == RW_READ) dout <= sr_q;
                else ack_out <= ack_bit_q;
            end
        end
    end

    i2c_bit_ctrl #(.CNT_W(CNT_W)) u_bit (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .ena     (ena),
        .clk_cnt (clk_cnt),
        .cmd     (bit_cmd),
        .din_bit (din_bit),
        .done    (done),
        .rx_bit  (rx_bit),
        .scl_i   (scl_i),
        .sda_i   (sda_i),
        .scl_oen (scl_oen),
        .sda_oen (sda_oen)
    );
endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// tb_i2c_byte_ctrl: randomized bench with a symbol-level bus model and slave
module tb_i2c_byte_ctrl;
    logic        clk = 0, arst_i = 1, ena = 1;
    logic [15:0] clk_cnt = 16'd4;
    logic        start = 0, stop = 0, read = 0, write = 0, ack_in = 0;
    logic [7:0]  din = 0, dout;
    logic        cmd_ack, ack_out, i2c_busy, i2c_al, scl_o, scl_oen, sda_o, sda_oen;
    logic        slave_sda = 1, stretch = 0, scl_i, sda_i;
    int          n_chk = 0, n_fail = 0, stop_cnt = 0, lat, stop0;
    logic        exp_busy = 0, exp_ack = 0;
    logic [7:0]  exp_dout = 0, got;
    logic        mon_bits[$];
    logic        prev_scl = 1, prev_sda = 1;
    logic [3:0]  start_scl = 4'b0111, start_sda = 4'b0011;
    logic [3:0]  stop_scl = 4'b1110, stop_sda = 4'b1000, bit_scl = 4'b0110;
    logic [3:0]  fl;

    typedef struct {int kind; logic v; logic slv;} sym_t;

    assign scl_i = scl_oen & ~stretch;
    assign sda_i = sda_oen & slave_sda;

    i2c_byte_ctrl #(.CNT_W(16)) dut (
        .clk_i(clk), .arst_i(arst_i), .ena(ena), .clk_cnt(clk_cnt),
        .start(start), .stop(stop), .read(read), .write(write), .ack_in(ack_in), .din(din),
        .cmd_ack(cmd_ack), .ack_out(ack_out), .i2c_busy(i2c_busy), .i2c_al(i2c_al), .dout(dout),
        .scl_i(scl_i), .scl_o(scl_o), .scl_oen(scl_oen),
        .sda_i(sda_i), .sda_o(sda_o), .sda_oen(sda_oen)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!prev_scl && scl_i) mon_bits.push_back(sda_i);
        if (prev_scl && scl_i && !prev_sda && sda_i) stop_cnt++;
        prev_scl = scl_i;
        prev_sda = sda_i;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // issue one command and compare every cycle against the symbol schedule
    task automatic run_cmd(input logic st, sp, rd, wr, ak, input logic [7:0] d, sb,
                           input logic sa, input int n, s_at, s_len, f_at, f_len, output int lt);
        sym_t syms[$];
        sym_t cur;
        int   nq, tot, m, qq, left_s, left_f;
        logic s_used, f_used, e_scl, e_sda, b;
        if (st) syms.push_back('{0, 1'b0, 1'b1});
        if (rd) begin
            for (int i = 0; i < 8; i++) syms.push_back('{3, 1'b1, sb[7-i]});
            syms.push_back('{2, ak, 1'b1});
        end else if (wr) begin
            for (int i = 0; i < 8; i++) syms.push_back('{2, d[7-i], 1'b1});
            syms.push_back('{3, 1'b1, sa});
        end
        if (sp) syms.push_back('{1, 1'b0, 1'b1});
        nq  = n + 1;
        tot = syms.size() * 4 * nq;
        clk_cnt = 16'(n);
        @(posedge clk); #1;
        start = st; stop = sp; read = rd; write = wr; ack_in = ak; din = d;
        @(posedge clk); #1;
        start = 0; stop = 0; read = 0; write = 0; din = 8'($urandom); ack_in = 1'($urandom);
        m = 1; lt = -1; left_s = 0; left_f = 0; s_used = 0; f_used = 0; b = exp_busy;
        for (int k = 1; k <= tot + s_len + f_len + 20; k++) begin
            @(negedge clk);
            cur = syms[m <= tot ? (m - 1) / (4 * nq) : syms.size() - 1];
            qq = m <= tot ? ((m - 1) / nq) % 4 : 3;
            e_scl = cur.kind == 0 ? start_scl[qq] : cur.kind == 1 ? stop_scl[qq] : bit_scl[qq];
            e_sda = cur.kind == 0 ? start_sda[qq] : cur.kind == 1 ? stop_sda[qq] : cur.kind == 2 ? cur.v : 1'b1;
            slave_sda = m <= tot ? cur.slv : 1'b1;
            if (m == tot + 3) begin
                if (rd) exp_dout = sb;
                else if (wr) exp_ack = sa;
            end
            b = exp_busy;
            if (st && m > 4 * nq) b = 1;
            if (sp && m > tot) b = 0;
            chk("scl_oen", scl_oen, e_scl);
            chk("sda_oen", sda_oen, e_sda);
            chk("cmd_ack", cmd_ack, m == tot + 3);
            chk("i2c_busy", i2c_busy, b);
            chk("ack_out", ack_out, exp_ack);
            chk("dout", dout, exp_dout);
            if (cmd_ack && lt < 0) lt = k - 1;
            if (!s_used && s_len > 0 && m == s_at) begin s_used = 1; left_s = s_len; end
            if (!f_used && f_len > 0 && m == f_at) begin f_used = 1; left_f = f_len; end
            stretch = left_s > 0;
            ena = !(left_f > 0);
            if (left_s > 0) left_s--;
            if (left_f > 0) left_f--;
            if (!stretch && ena) m++;
            if (m > tot + 3) break;
        end
        stretch = 0; ena = 1; slave_sda = 1;
        exp_busy = b;
        if (lt < 0) chk("cmd_ack_timeout", 0, 1);
    endtask

    function automatic logic [7:0] mon_byte();
        logic [7:0] r = 0;
        for (int i = 0; i < 8; i++) r = {r[6:0], mon_bits[i]};
        return r;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_scl_oen", scl_oen, 1);
        chk("rst_sda_oen", sda_oen, 1);
        chk("rst_cmd_ack", cmd_ack, 0);
        chk("rst_ack_out", ack_out, 0);
        chk("rst_dout", dout, 0);
        chk("rst_busy", i2c_busy, 0);
        chk("i2c_al", i2c_al, 0);
        chk("pad_o", {scl_o, sda_o}, 0);
        @(posedge clk); #1 arst_i = 0;

        mon_bits.delete();
        run_cmd(1, 0, 0, 1, 0, 8'hE8, 8'h00, 0, 4, 0, 0, 0, 0, lat);
        chk("t1_latency", lat, 202);
        chk("t1_nbits", mon_bits.size(), 9);
        chk("t1_bus_byte", mon_byte(), 8'hE8);
        chk("t1_ack_out", ack_out, 0);
        chk("t1_busy", i2c_busy, 1);

        mon_bits.delete(); stop0 = stop_cnt;
        run_cmd(0, 0, 0, 1, 0, 8'h3C, 8'h00, 1, 3, 0, 0, 0, 0, lat);
        chk("t2_latency", lat, 146);
        chk("t2_ack_out", ack_out, 1);
        chk("t2_no_stop", stop_cnt, stop0);
        chk("t2_bus_byte", mon_byte(), 8'h3C);

        stop0 = stop_cnt;
        run_cmd(0, 1, 1, 0, 1, 8'h00, 8'hA5, 1, 2, 0, 0, 0, 0, lat);
        chk("t3_latency", lat, 122);
        chk("t3_dout", dout, 8'hA5);
        chk("t3_stop_seen", stop_cnt, stop0 + 1);
        chk("t3_busy", i2c_busy, 0);

        mon_bits.delete();
        run_cmd(0, 0, 0, 1, 0, 8'h5A, 8'h00, 0, 2, 40, 50, 0, 0, lat);
        chk("t4_stretch_latency", lat, 160);
        chk("t4_bus_byte", mon_byte(), 8'h5A);
        chk("t4_ack_out", ack_out, 0);

        run_cmd(0, 0, 0, 1, 0, 8'h96, 8'h00, 1, 1, 0, 0, 20, 30, lat);
        chk("t5_freeze_latency", lat, 104);

        clk_cnt = 16'd4;
        @(posedge clk); #1 start = 1; write = 1; din = 8'h00;
        @(posedge clk); #1 start = 0; write = 0;
        repeat (60) @(posedge clk);
        #1 arst_i = 1;
        @(negedge clk);
        chk("t6_rst_scl_oen", scl_oen, 1);
        chk("t6_rst_sda_oen", sda_oen, 1);
        chk("t6_rst_cmd_ack", cmd_ack, 0);
        chk("t6_rst_busy", i2c_busy, 0);
        repeat (3) @(posedge clk);
        #1 arst_i = 0;
        exp_busy = 0; exp_ack = 0; exp_dout = 0;
        stop0 = stop_cnt;
        run_cmd(0, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, lat);
        chk("t6_bare_stop_latency", lat, 6);
        chk("t6_stop_seen", stop_cnt, stop0 + 1);

        for (int t = 0; t < 16; t++) begin
            int n;
            fl = 4'($urandom_range(1, 15));
            n  = $urandom_range(0, 3);
            run_cmd(fl[3], fl[2], fl[1], fl[0], 1'($urandom), 8'($urandom), 8'($urandom),
                    1'($urandom), n, 0, 0, 0, 0, lat);
            chk("rand_latency", lat, 4 * (n + 1) * (int'(fl[3]) + int'(fl[2]) + 9 * int'(fl[1] | fl[0])) + 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_byte_ctrl.md
Name: i2c_byte_ctrl

Overview:
Byte-level I2C master engine. A controller issues one command per handshake (optional START, one byte write or read, optional STOP). The engine serialises it onto open-drain SCL/SDA pads and pulses cmd_ack when the command is done. It sits between configuration loaders (e.g. the Si5340 loader) and the I2C pads, with the command side bundled in interface i2_ctrl_if.

Parameters:
CNT_W, 16, width of the clk_cnt prescale input

Ports:
clk_i  in  1  system clock
arst_i  in  1  asynchronous reset, active-high
ena  in  1  core enable; 0 freezes the prescaler and bit engine
clk_cnt  in  CNT_W  SCL quarter-period = clk_cnt+1 clk_i cycles
start  in  1  generate START (or repeated START) before the byte
stop  in  1  generate STOP after the byte, or alone
read  in  1  read one byte
write  in  1  write din
ack_in  in  1  ACK bit driven on a read (0=ACK, 1=NACK)
din  in  8  byte to write, MSB first
cmd_ack  out  1  one-cycle pulse, command complete
ack_out  out  1  slave ACK sampled on a write (0=ACK)
i2c_busy  out  1  bus owned: START done, STOP not yet done
i2c_al  out  1  arbitration lost; tied 0 (single-master design)
dout  out  8  byte received on a read
scl_i  in  1  SCL pad input
scl_o  out  1  SCL pad output, constant 0
scl_oen  out  1  SCL output enable, active-low (1 = release)
sda_i  in  1  SDA pad input
sda_o  out  1  SDA pad output, constant 0
sda_oen  out  1  SDA output enable, active-low

Behaviour:
- Reset values: scl_oen=1, sda_oen=1, cmd_ack=0, ack_out=0, dout=0, i2c_busy=0, i2c_al=0. FSM goes to IDLE. Reset mid-transfer aborts immediately and releases both lines.
- Command accept: in IDLE with ena=1, any of start/stop/read/write high is accepted on that edge. All flags, din and ack_in are latched, so a one-cycle pulse is enough. Inputs are ignored outside IDLE.
- Sequence order: START if start is set; then READ if read, else WRITE if write; then STOP if stop is set. read and write both high means READ. stop alone gives a bare STOP.
- FSM states: IDLE, START, WRITE, READ, ACK, STOP, DONE. DONE pulses cmd_ack for one cycle and returns to IDLE.
- Bit timing: every bus symbol is 4 quarters of clk_cnt+1 cycles each.
  - START: SDA=1/SCL=1, SDA=1/SCL=1, SDA=0/SCL=1, SDA=0/SCL=0.
  - STOP: SDA=0/SCL=0, SDA=0/SCL=1, SDA=0/SCL=1, SDA=1/SCL=1.
  - Data bit: SCL low, high, high, low, with SDA held for all 4 quarters.
  - Read bit: SDA released; sda_i is sampled at the end of quarter 2.
- Byte: 8 data bits MSB first, then a 9th bit.
  - Write: SDA released on the 9th bit; ack_out takes sda_i.
  - Read: 9th bit drives ack_in; dout is loaded with the shifted byte.
- Clock stretching: in any quarter where SCL is released, the quarter counter holds while scl_i=0.
- Latency: cmd_ack rises exactly 2 cycles after the last quarter of the last symbol. The stretch time adds to this.
  - Example: START+WRITE = 40*(clk_cnt+1)+2 cycles from the accept edge.
- ack_out and dout update on the same edge that cmd_ack rises, and hold until the next command of the same kind.
- i2c_busy: set when the START symbol completes, cleared when the STOP symbol completes.
- ena=0 freezes the counter and all outputs at their current values. clk_cnt=0 is legal (1-cycle quarter).

Decomposition:
- Shared package i2c_pkg:
  - r_w typedef (WRITE=0, READ=1)
  - bit-command enum (CMD_NOP, CMD_START, CMD_STOP, CMD_WRITE, CMD_READ)
  - byte FSM state enum
  - DATA_WIDTH=8
- Interface i2_ctrl_if, in its own file, bundles start, stop, read, write, ack_in, din, cmd_ack, dout. It has modports host and engine.
- One sub-module, i2c_bit_ctrl. It holds the prescaler, quarter sequencing, stretching and pad drive, and executes a single bit command with a done pulse. i2c_byte_ctrl keeps the byte FSM, shift register and bit counter.

Test Plan:
- clk_cnt=4, start+write, din=0xE8, slave model ACKs -> SDA bits 1,1,1,0,1,0,0,0; ack_out=0; cmd_ack at 202 cycles after accept; i2c_busy=1.
- write, din=0x3C, no slave (SDA pulled high) -> ack_out=1, one cmd_ack, no STOP on the bus.
- read+stop+ack_in=1, slave drives 0xA5 -> dout=0xA5; SDA released on the 9th bit; STOP seen (SDA rises while SCL high); i2c_busy=0 after.
- Slave holds scl_i low 50 cycles during bit 3 of a write -> cmd_ack delayed by exactly 50 cycles; data intact.
- Assert arst_i mid-byte -> scl_oen=sda_oen=1, cmd_ack=0 during reset; after release, a bare stop command completes normally.
- ena=0 held 30 cycles mid-write -> pads frozen; completion delayed by 30 cycles.
